// File: rtl/mulu_arb.sv
// Two-requester arbiter in front of a shared combinational unsigned multiplier.
// Optional MULU_ARB_ROUND_ROBIN_EN selects round-robin tie-breaking (default: requester 0 wins ties).
module mulu_arb #(
  parameter  int X_WIDTH = 3,
  parameter  int Y_WIDTH = 3,
  localparam int P_WIDTH = X_WIDTH + Y_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0,
  input  logic               req1,
  input  logic [X_WIDTH-1:0] x0,
  input  logic [X_WIDTH-1:0] x1,
  input  logic [Y_WIDTH-1:0] y0,
  input  logic [Y_WIDTH-1:0] y1,
  output logic               gnt0,
  output logic               gnt1,
  output logic               done0,
  output logic               done1,
  output logic [P_WIDTH-1:0] p_out,
  output logic               busy,
  output logic [X_WIDTH-1:0] mul_x,
  output logic [Y_WIDTH-1:0] mul_y,
  input  logic [P_WIDTH-1:0] mul_p
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_grant;
  logic                 w_win1;
  logic [X_WIDTH-1:0]   r_x;
  logic [Y_WIDTH-1:0]   r_y;
  logic                 r_owner;
  logic                 r_gnt0;
  logic                 r_gnt1;
  logic                 r_done0;
  logic                 r_done1;
  logic [P_WIDTH-1:0]   r_p;

`ifdef MULU_ARB_ROUND_ROBIN_EN
  // High when requester 1 was served last; reset so requester 0 wins the first tie.
  logic r_last1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last1 <= 1'b1;
    end else if (w_grant) begin
      r_last1 <= w_win1;
    end
  end

  always_comb begin
    w_win1 = req1 & (~req0 | ~r_last1);
  end
`else
  always_comb begin
    w_win1 = req1 & ~req0;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    case (r_state)
      IDLE: begin
        if (req0 | req1) begin
          w_grant     = 1'b1;
          w_state_nxt = CALC;
        end
      end
      CALC:    w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x     <= '0;
      r_y     <= '0;
      r_owner <= 1'b0;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_p     <= '0;
    end else begin
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      if (w_grant) begin
        r_x     <= w_win1 ? x1 : x0;
        r_y     <= w_win1 ? y1 : y0;
        r_owner <= w_win1;
        r_gnt0  <= ~w_win1;
        r_gnt1  <= w_win1;
      end else if (r_state == CALC) begin
        r_gnt0  <= 1'b0;
        r_gnt1  <= 1'b0;
        r_p     <= mul_p;
        r_done0 <= ~r_owner;
        r_done1 <= r_owner;
      end
    end
  end

  // The shared multiplier only sees our operands while we own it.
  always_comb begin
    mul_x = '0;
    mul_y = '0;
    if (r_state == CALC) begin
      mul_x = r_x;
      mul_y = r_y;
    end
  end

  assign gnt0  = r_gnt0;
  assign gnt1  = r_gnt1;
  assign done0 = r_done0;
  assign done1 = r_done1;
  assign p_out = r_p;
  assign busy  = (r_state != IDLE);

endmodule

// File: tb/tb_mulu_arb.sv
// Scoreboard bench for mulu_arb: random and directed requests against a transaction-level model.
module tb_mulu_arb;
  localparam int XW = 3;
  localparam int YW = 3;
  localparam int PW = XW + YW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [XW-1:0] x0 = '0, x1 = '0;
  logic [YW-1:0] y0 = '0, y1 = '0;
  logic          gnt0, gnt1, done0, done1, busy;
  logic [PW-1:0] p_out, mul_p;
  logic [XW-1:0] mul_x;
  logic [YW-1:0] mul_y;

  mulu_arb #(.X_WIDTH(XW), .Y_WIDTH(YW)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1),
    .x0(x0), .x1(x1), .y0(y0), .y1(y1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .p_out(p_out), .busy(busy),
    .mul_x(mul_x), .mul_y(mul_y), .mul_p(mul_p)
  );

  // Shared combinational multiplier outside the arbiter.
  assign mul_p = PW'(mul_x) * PW'(mul_y);

  always #5 clk = ~clk;

  typedef struct {
    int owner;
    int x;
    int y;
    int prod;
    int g;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   next_free = 0;
  int   last = 1;
  int   exp_p = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference model: an operation takes 3 cycles; a new grant is possible 3 edges after the last one.
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      next_free = cyc + 1;
    end else if (cyc >= next_free && (req0 || req1)) begin
      exp_t e;
      int   w;
      if (req0 && req1) begin
`ifdef MULU_ARB_ROUND_ROBIN_EN
        w = (last == 1) ? 0 : 1;
`else
        w = 0;
`endif
      end else begin
        w = req1 ? 1 : 0;
      end
      e.owner = w;
      e.x     = w ? int'(x1) : int'(x0);
      e.y     = w ? int'(y1) : int'(y0);
      e.prod  = e.x * e.y;
      e.g     = cyc;
      q.push_back(e);
      next_free = cyc + 3;
      last      = w;
    end
  end

  // Monitor on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      chk("reset_outs", int'({gnt0, gnt1, done0, done1, busy}), 0);
      chk("reset_p_out", int'(p_out), 0);
      chk("reset_mul", int'({mul_x, mul_y}), 0);
    end else begin
      int exp_busy;
      int in_calc;
      exp_busy = (q.size() != 0) ? 1 : 0;
      chk("busy", int'(busy), exp_busy);
      chk("done_excl", int'(done0 & done1), 0);
      chk("gnt_excl", int'(gnt0 & gnt1), 0);
      if (done0 || done1) begin
        if (q.size() == 0) begin
          chk("unexpected_done", int'({done0, done1}), 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("done_owner", int'(done1), e.owner);
          chk("done_cycle", cyc, e.g + 1);
          exp_p = e.prod;
        end
      end else if (q.size() != 0 && cyc > q[0].g) begin
        exp_t e;
        e = q.pop_front();
        chk("missing_done", 0, 1);
      end
      in_calc = (q.size() != 0 && q[0].g == cyc) ? 1 : 0;
      chk("gnt0", int'(gnt0), (in_calc != 0 && q[0].owner == 0) ? 1 : 0);
      chk("gnt1", int'(gnt1), (in_calc != 0 && q[0].owner == 1) ? 1 : 0);
      chk("mul_x", int'(mul_x), (in_calc != 0) ? q[0].x : 0);
      chk("mul_y", int'(mul_y), (in_calc != 0) ? q[0].y : 0);
      chk("p_out", int'(p_out), exp_p);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    q.delete();
    exp_p = 0;
    last  = 1;
    step(1);
    reset = 1'b0;
  endtask

  initial begin
    step(3);
    reset = 1'b0;

    // 5x7 from reset, request dropped at DONE
    req0 = 1'b1; x0 = 3'd5; y0 = 3'd7;
    step(2);
    req0 = 1'b0;
    step(2);
    chk("first_p_out", int'(p_out), 35);
    chk("first_idle", int'(busy), 0);

    // Both held: alternation (round-robin) or requester 0 only (fixed)
    req0 = 1'b1; x0 = 3'd3; y0 = 3'd3;
    req1 = 1'b1; x1 = 3'd7; y1 = 3'd7;
    step(12);
    req0 = 1'b0; req1 = 1'b0;
    step(3);

    // 7x7 max and 0x5 zero
    req1 = 1'b1; x1 = 3'd7; y1 = 3'd7;
    step(1);
    req1 = 1'b0;
    step(3);
    chk("max_p_out", int'(p_out), 49);
    req0 = 1'b1; x0 = 3'd0; y0 = 3'd5;
    step(1);
    req0 = 1'b0;
    step(3);
    chk("zero_p_out", int'(p_out), 0);

    // Operand change during CALC must not matter
    req0 = 1'b1; x0 = 3'd7; y0 = 3'd7;
    step(1);
    x0 = 3'd1; y0 = 3'd0; req0 = 1'b0;
    step(3);
    chk("late_change_p_out", int'(p_out), 49);

    // Reset during CALC aborts
    req1 = 1'b1; x1 = 3'd6; y1 = 3'd5;
    step(1);
    req1 = 1'b0;
    do_reset();
    step(3);
    chk("abort_p_out", int'(p_out), 0);
    chk("abort_idle", int'(busy), 0);

    // Request dropped during CALC still completes
    req1 = 1'b1; x1 = 3'd6; y1 = 3'd6;
    step(1);
    req1 = 1'b0;
    step(3);
    chk("drop_p_out", int'(p_out), 36);

    // Random traffic with occasional reset
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        req0 = ($urandom_range(0, 2) != 0);
        req1 = ($urandom_range(0, 2) != 0);
        x0 = XW'($urandom); y0 = YW'($urandom);
        x1 = XW'($urandom); y1 = YW'($urandom);
        step(1);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    step(5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mulu_arb.md
MULU_ARB -- requirements
Module: mulu_arb

Interface
REQ-001 Parameter X_WIDTH, default 3, multiplicand width.
REQ-002 Parameter Y_WIDTH, default 3, multiplier width; P_WIDTH is X_WIDTH+Y_WIDTH (6 by default).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req0, req1  input  1 each  request from requester 0 / 1; level-held.
REQ-006 x0, x1  input  X_WIDTH each  operand x of requester 0 / 1.
REQ-007 y0, y1  input  Y_WIDTH each  operand y of requester 0 / 1.
REQ-008 gnt0, gnt1  output  1 each  registered grant; high during the CALC cycle of that requester's operation.
REQ-009 done0, done1  output  1 each  single-cycle completion pulse to the owner.
REQ-010 p_out  output  P_WIDTH  registered product of the last completed operation.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 mul_x  output  X_WIDTH  operand to the shared combinational multiplier.
REQ-013 mul_y  output  Y_WIDTH  operand to the shared combinational multiplier.
REQ-014 mul_p  input  P_WIDTH  unsigned product returned by the shared multiplier.

Function
REQ-015 The block SHALL implement a 3-state FSM: IDLE, CALC, DONE.
REQ-016 IDLE: if any req is high at a clock edge, the block SHALL latch the winner's x/y into operand registers, record the owner, assert its gnt, and go to CALC; otherwise it SHALL stay in IDLE.
REQ-017 CALC: mul_x/mul_y SHALL drive the operand registers; at the edge ending CALC, mul_p SHALL be captured into p_out and the FSM SHALL go to DONE.
REQ-018 DONE: done of the owner SHALL be high for exactly this cycle, with p_out already valid; the FSM SHALL return to IDLE at the next edge.
REQ-019 Latency: req sampled at edge E0 -> gnt high E0..E1 -> done high E1..E2 -> IDLE at E2. Throughput: one operation per 3 cycles.
REQ-020 Operands SHALL be sampled only at the granting edge; later operand changes SHALL NOT affect the result.
REQ-021 In IDLE and DONE, mul_x and mul_y SHALL be 0.
REQ-022 p_out SHALL hold its value until the next CALC capture.
REQ-023 Products are unsigned, full width P_WIDTH; no truncation or saturation.
REQ-024 A req dropped after grant SHALL NOT abort the operation; done SHALL still pulse.
REQ-025 A req still high in the IDLE cycle after DONE SHALL be treated as a new request, with operands sampled fresh.
REQ-026 gnt0/gnt1 and done0/done1 SHALL be mutually exclusive pairs.

Reset
REQ-027 reset SHALL asynchronously force state IDLE and gnt0/1, done0/1, busy, p_out, mul_x, mul_y and the operand registers to 0.
REQ-028 The last-served pointer SHALL reset to requester 1, so requester 0 wins the first tie.
REQ-029 Reset during CALC or DONE SHALL abort the operation; no done pulse follows.

Configuration
REQ-030 Macro MULU_ARB_ROUND_ROBIN_EN defined: on a tie in IDLE, the requester not served last SHALL win, and the pointer SHALL update at each grant.
REQ-031 Macro undefined: requester 0 SHALL always win ties (fixed priority), starvation of requester 1 is permitted, and the pointer logic SHALL be absent.

Verification
REQ-032 req0=1, x0=5, y0=7, req1=0 from reset -> gnt0 one cycle, done0 one cycle later, p_out=35; req0 dropped at done -> IDLE, busy=0.
REQ-033 Round-robin build, req0 (3x3) and req1 (7x7) held -> grants alternate 0,1,0,1; p_out alternates 9, 49; each done arrives 3 cycles after the previous one.
REQ-034 Fixed-priority build, same stimulus -> only gnt0/done0 ever assert; p_out=9 every 3 cycles.
REQ-035 Boundaries: 7x7 -> 49; 0x5 -> 0; x0 changed to 1 during CALC -> result unaffected.
REQ-036 reset pulsed during CALC -> no done, p_out=0, state IDLE; req1 dropped during CALC -> done1 still pulses with the correct product.
